// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if: CPU, debug and data-memory buses seen by the data-memory arbiter
interface dmem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_rvalid;
  logic              cpu_stall;
  logic              dbg_req;
  logic              dbg_we;
  logic [ADDR_W-1:0] dbg_addr;
  logic [DATA_W-1:0] dbg_wdata;
  logic              dbg_gnt;
  logic [DATA_W-1:0] dbg_rdata;
  logic              dbg_rvalid;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_rdata, cpu_rvalid, cpu_stall,
    input  dbg_req, dbg_we, dbg_addr, dbg_wdata,
    output dbg_gnt, dbg_rdata, dbg_rvalid,
    output mem_en, mem_we, mem_addr, mem_wdata,
    input  mem_rdata
  );
  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_rdata, cpu_rvalid, cpu_stall,
    output dbg_req, dbg_we, dbg_addr, dbg_wdata,
    input  dbg_gnt, dbg_rdata, dbg_rvalid,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: CPU-priority data-memory arbiter with debug port; DMEM_ARB_STARVE_EN adds the starvation guard
module dmem_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 8
) (
  input logic           clk_i,
  input logic           reset_i,
  dmem_arbiter_if.slave bus
);
  logic              dbg_pri;
  logic              cpu_own;
  logic              dbg_own;
  logic              cpu_rv;
  logic              dbg_rv;
  logic              rd_q;
  logic              rd_dbg_q;
  logic [DATA_W-1:0] cpu_rdata_q;
  logic [DATA_W-1:0] dbg_rdata_q;
`ifdef DMEM_ARB_STARVE_EN
  typedef enum logic {CPU_PRI, DBG_PRI} state_t;
  localparam logic [7:0] CNT_LAST = 8'(STARVE_MAX - 1);
  localparam logic [7:0] CNT_MAX  = 8'(STARVE_MAX);
  state_t     state_q;
  logic [7:0] cnt_q;
  logic [7:0] cnt_d;
  assign dbg_pri = state_q == DBG_PRI;
  assign bus.cpu_stall = ~reset_i & dbg_pri & bus.cpu_req & bus.dbg_req;
  // Wait counter restarts whenever the debug port is served or stops asking
  always_comb begin
    cnt_d = (~bus.dbg_req | dbg_own) ? 8'd0 : (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 8'd1;
  end
  // Priority FSM: one DBG_PRI cycle after the last tolerated lost cycle
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= CPU_PRI;
      cnt_q   <= 8'd0;
    end else begin
      state_q <= (state_q == CPU_PRI && bus.dbg_req && !dbg_own && cnt_q == CNT_LAST) ? DBG_PRI : CPU_PRI;
      cnt_q   <= cnt_d;
    end
  end
`else
  assign dbg_pri = 1'b0;
  assign bus.cpu_stall = 1'b0;
`endif
  assign cpu_own = ~reset_i & bus.cpu_req & ~(dbg_pri & bus.dbg_req);
  assign dbg_own = ~reset_i & bus.dbg_req & (~bus.cpu_req | dbg_pri);
  assign bus.dbg_gnt   = dbg_own;
  assign bus.mem_en    = cpu_own | dbg_own;
  assign bus.mem_we    = dbg_own ? bus.dbg_we : cpu_own & bus.cpu_we;
  assign bus.mem_addr  = dbg_own ? bus.dbg_addr : cpu_own ? bus.cpu_addr : '0;
  assign bus.mem_wdata = dbg_own ? bus.dbg_wdata : cpu_own ? bus.cpu_wdata : '0;
  // Remember who issued a read so the returning data goes to the right requester
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      rd_q     <= 1'b0;
      rd_dbg_q <= 1'b0;
    end else begin
      rd_q     <= bus.mem_en & ~bus.mem_we;
      rd_dbg_q <= dbg_own;
    end
  end
  assign cpu_rv = ~reset_i & rd_q & ~rd_dbg_q;
  assign dbg_rv = ~reset_i & rd_q & rd_dbg_q;
  assign bus.cpu_rvalid = cpu_rv;
  assign bus.dbg_rvalid = dbg_rv;
  assign bus.cpu_rdata  = cpu_rv ? bus.mem_rdata : cpu_rdata_q;
  assign bus.dbg_rdata  = dbg_rv ? bus.mem_rdata : dbg_rdata_q;
  // Each requester keeps its last returned word until its next read completes
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      cpu_rdata_q <= '0;
      dbg_rdata_q <= '0;
    end else begin
      cpu_rdata_q <= cpu_rv ? bus.mem_rdata : cpu_rdata_q;
      dbg_rdata_q <= dbg_rv ? bus.mem_rdata : dbg_rdata_q;
    end
  end
endmodule
